// File: rtl/vga_pkg.sv
// Shared types and default timing for the VGA scan-out path.
package vga_pkg;

  localparam int unsigned BYTE_BITS = 8;

  localparam int unsigned DEF_PIX_DIV     = 2;
  localparam int unsigned DEF_H_VISIBLE   = 640;
  localparam int unsigned DEF_H_FRONT     = 16;
  localparam int unsigned DEF_H_SYNC      = 96;
  localparam int unsigned DEF_H_BACK      = 48;
  localparam int unsigned DEF_V_VISIBLE   = 480;
  localparam int unsigned DEF_V_FRONT     = 10;
  localparam int unsigned DEF_V_SYNC      = 2;
  localparam int unsigned DEF_V_BACK      = 33;
  localparam int unsigned DEF_SCALE_SHIFT = 1;
  localparam int unsigned DEF_ADDR_BITS   = 17;

  typedef enum logic [1:0] {
    VGA_IDLE  = 2'd0,
    VGA_RUN   = 2'd1,
    VGA_DRAIN = 2'd2
  } vga_state_t;

  // Total positions on one axis (visible + front porch + sync + back porch).
  function automatic int unsigned axis_total(input int unsigned vis, input int unsigned front,
                                             input int unsigned sync, input int unsigned back);
    return vis + front + sync + back;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with registered visible/sync/last-position flags.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int unsigned VIS   = DEF_H_VISIBLE,
  parameter int unsigned FRONT = DEF_H_FRONT,
  parameter int unsigned SYNC  = DEF_H_SYNC,
  parameter int unsigned BACK  = DEF_H_BACK,
  parameter int unsigned W     = 10
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] pos,
  output logic         visible,
  output logic         sync,
  output logic         wrap
);

  localparam int unsigned TOTAL = axis_total(VIS, FRONT, SYNC, BACK);
  localparam logic [W-1:0] LAST    = W'(TOTAL - 1);
  localparam logic [W-1:0] VIS_END = W'(VIS);
  localparam logic [W-1:0] SYNC_LO = W'(VIS + FRONT);
  localparam logic [W-1:0] SYNC_HI = W'(VIS + FRONT + SYNC);
  localparam logic VIS_AT0  = (VIS > 0);
  localparam logic SYNC_AT0 = ((VIS + FRONT) == 0) && (SYNC > 0);
  localparam logic WRAP_AT0 = (TOTAL == 1);

  logic [W-1:0] pos_nxt;

  always_comb begin
    pos_nxt = pos;
    if (clr) begin
      pos_nxt = '0;
    end else if (inc) begin
      pos_nxt = (pos == LAST) ? '0 : pos + W'(1);
    end
  end

  // Flags are registered from the next position so they line up with pos.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos     <= '0;
      visible <= VIS_AT0;
      sync    <= SYNC_AT0;
      wrap    <= WRAP_AT0;
    end else begin
      pos     <= pos_nxt;
      visible <= (pos_nxt < VIS_END);
      sync    <= (pos_nxt >= SYNC_LO) && (pos_nxt < SYNC_HI);
      wrap    <= (pos_nxt == LAST);
    end
  end

endmodule

// File: rtl/vga_scan_ctrl.sv
// VGA scan sequencer: raster timing, frame-buffer read issue, and a one-tick
// alignment stage that presents the returned byte with matching sync.
module vga_scan_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned PIX_DIV     = DEF_PIX_DIV,
  parameter int unsigned H_VISIBLE   = DEF_H_VISIBLE,
  parameter int unsigned H_FRONT     = DEF_H_FRONT,
  parameter int unsigned H_SYNC      = DEF_H_SYNC,
  parameter int unsigned H_BACK      = DEF_H_BACK,
  parameter int unsigned V_VISIBLE   = DEF_V_VISIBLE,
  parameter int unsigned V_FRONT     = DEF_V_FRONT,
  parameter int unsigned V_SYNC      = DEF_V_SYNC,
  parameter int unsigned V_BACK      = DEF_V_BACK,
  parameter int unsigned SCALE_SHIFT = DEF_SCALE_SHIFT,
  parameter int unsigned ADDR_BITS   = DEF_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 enable,
  output logic                 rd_en,
  output logic [ADDR_BITS-1:0] rd_addr,
  input  logic [BYTE_BITS-1:0] rd_data,
  output logic [BYTE_BITS-1:0] pixel_byte,
  output logic                 hsync,
  output logic                 vsync,
  output logic                 frame_start,
  output logic                 busy
);

  localparam int unsigned H_TOTAL = axis_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
  localparam int unsigned V_TOTAL = axis_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);
  localparam int unsigned HW      = $clog2(H_TOTAL + 1);
  localparam int unsigned VW      = $clog2(V_TOTAL + 1);
  localparam int unsigned DW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
  localparam logic [ADDR_BITS-1:0] FB_W = ADDR_BITS'(H_VISIBLE >> SCALE_SHIFT);

  vga_state_t state, state_nxt;
  logic [DW-1:0] div, div_nxt;
  logic flush, flush_nxt, flushed, flushed_nxt;
  logic vis_d, vis_d_nxt, hs_d, hs_d_nxt, vs_d, vs_d_nxt, first_d, first_d_nxt;
  logic rd_en_nxt, hsync_nxt, vsync_nxt, frame_start_nxt, busy_nxt;
  logic [ADDR_BITS-1:0] rd_addr_nxt, addr_c;
  logic [BYTE_BITS-1:0] pixel_byte_nxt;

  logic [HW-1:0] h_pos;
  logic [VW-1:0] v_pos;
  logic h_vis, h_sync, h_wrap, v_vis, v_sync, v_wrap;
  logic running_c, phase_c, tick_c, frame_end_c, cnt_clr_c;

  vga_axis_counter #(
    .VIS(H_VISIBLE), .FRONT(H_FRONT), .SYNC(H_SYNC), .BACK(H_BACK), .W(HW)
  ) u_h_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr_c), .inc(tick_c),
    .pos(h_pos), .visible(h_vis), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .VIS(V_VISIBLE), .FRONT(V_FRONT), .SYNC(V_SYNC), .BACK(V_BACK), .W(VW)
  ) u_v_cnt (
    .clk(clk), .reset(reset), .clr(cnt_clr_c), .inc(tick_c && h_wrap),
    .pos(v_pos), .visible(v_vis), .sync(v_sync), .wrap(v_wrap)
  );

  // Reads are issued at div==0; the previous pixel is captured on that same edge,
  // giving exactly PIX_DIV clocks between rd_en and the byte on pixel_byte.
  assign running_c   = (state != VGA_IDLE);
  assign phase_c     = running_c && (div == '0);
  assign tick_c      = running_c && (div == DIV_LAST) && !flush && !flushed;
  assign frame_end_c = tick_c && h_wrap && v_wrap;

  always_comb begin
    addr_c = ADDR_BITS'(v_pos >> SCALE_SHIFT) * FB_W + ADDR_BITS'(h_pos >> SCALE_SHIFT);
  end

  always_comb begin
    state_nxt       = state;
    div_nxt         = div;
    flush_nxt       = flush;
    flushed_nxt     = flushed;
    vis_d_nxt       = vis_d;
    hs_d_nxt        = hs_d;
    vs_d_nxt        = vs_d;
    first_d_nxt     = first_d;
    rd_en_nxt       = 1'b0;
    rd_addr_nxt     = rd_addr;
    pixel_byte_nxt  = pixel_byte;
    hsync_nxt       = hsync;
    vsync_nxt       = vsync;
    frame_start_nxt = 1'b0;
    cnt_clr_c       = 1'b0;

    if (running_c) begin
      div_nxt = (div == DIV_LAST) ? '0 : div + DW'(1);
    end

    if (phase_c) begin
      pixel_byte_nxt = vis_d ? rd_data : '0;
      hsync_nxt      = ~hs_d;
      vsync_nxt      = ~vs_d;
      if (flush || flushed) begin
        // End-of-frame flush: emit the last staged pixel, issue nothing new.
        flush_nxt   = 1'b0;
        flushed_nxt = flush;
        vis_d_nxt   = 1'b0;
        hs_d_nxt    = 1'b0;
        vs_d_nxt    = 1'b0;
        first_d_nxt = 1'b0;
      end else begin
        frame_start_nxt = first_d;
        rd_en_nxt       = h_vis && v_vis;
        if (h_vis && v_vis) begin
          rd_addr_nxt = addr_c;
        end
        vis_d_nxt   = h_vis && v_vis;
        hs_d_nxt    = h_sync;
        vs_d_nxt    = v_sync;
        first_d_nxt = (h_pos == '0) && (v_pos == '0);
      end
    end

    if (frame_end_c && (state == VGA_DRAIN) && !enable) begin
      flush_nxt = 1'b1;
    end

    case (state)
      VGA_IDLE: begin
        if (enable) begin
          state_nxt = VGA_RUN;
          div_nxt   = '0;
          cnt_clr_c = 1'b1;
        end
      end
      VGA_RUN: begin
        if (!enable) begin
          state_nxt = VGA_DRAIN;
        end
      end
      VGA_DRAIN: begin
        if (enable) begin
          state_nxt   = VGA_RUN;
          flush_nxt   = 1'b0;
          flushed_nxt = 1'b0;
        end else if (flushed && phase_c) begin
          state_nxt       = VGA_IDLE;
          div_nxt         = '0;
          cnt_clr_c       = 1'b1;
          flush_nxt       = 1'b0;
          flushed_nxt     = 1'b0;
          vis_d_nxt       = 1'b0;
          hs_d_nxt        = 1'b0;
          vs_d_nxt        = 1'b0;
          first_d_nxt     = 1'b0;
          rd_en_nxt       = 1'b0;
          rd_addr_nxt     = '0;
          pixel_byte_nxt  = '0;
          hsync_nxt       = 1'b1;
          vsync_nxt       = 1'b1;
          frame_start_nxt = 1'b0;
        end
      end
      default: state_nxt = VGA_IDLE;
    endcase

    busy_nxt = (state_nxt != VGA_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= VGA_IDLE;
      div         <= '0;
      flush       <= 1'b0;
      flushed     <= 1'b0;
      vis_d       <= 1'b0;
      hs_d        <= 1'b0;
      vs_d        <= 1'b0;
      first_d     <= 1'b0;
      rd_en       <= 1'b0;
      rd_addr     <= '0;
      pixel_byte  <= '0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      div         <= div_nxt;
      flush       <= flush_nxt;
      flushed     <= flushed_nxt;
      vis_d       <= vis_d_nxt;
      hs_d        <= hs_d_nxt;
      vs_d        <= vs_d_nxt;
      first_d     <= first_d_nxt;
      rd_en       <= rd_en_nxt;
      rd_addr     <= rd_addr_nxt;
      pixel_byte  <= pixel_byte_nxt;
      hsync       <= hsync_nxt;
      vsync       <= vsync_nxt;
      frame_start <= frame_start_nxt;
      busy        <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_vga_scan_ctrl.sv
// Directed bench for vga_scan_ctrl on a tiny 4x3 raster (7x6 total) with a scoreboard
// of expected pixel outputs, one pixel tick behind the read that produced them.
module tb_vga_scan_ctrl;

  localparam int unsigned AB = 17;
  localparam int HT = 7;
  localparam int VT = 6;

  typedef struct packed {
    logic [7:0] b;
    logic       hs;
    logic       vs;
    logic       fs;
  } exp_t;

  localparam exp_t BLANK = '{b: 8'h00, hs: 1'b1, vs: 1'b1, fs: 1'b0};

  logic          clk;
  logic          rst_n;
  logic          enable;
  logic          rd_en;
  logic [AB-1:0] rd_addr;
  logic [7:0]    rd_data;
  logic [7:0]    pixel_byte;
  logic          hsync, vsync, frame_start, busy;

  int   checks = 0;
  int   errors = 0;
  int   mx = 0;
  int   my = 0;
  exp_t sb[$];

  vga_scan_ctrl #(
    .PIX_DIV(2),
    .H_VISIBLE(4), .H_FRONT(1), .H_SYNC(1), .H_BACK(1),
    .V_VISIBLE(3), .V_FRONT(1), .V_SYNC(1), .V_BACK(1),
    .SCALE_SHIFT(0), .ADDR_BITS(AB)
  ) dut (
    .clk(clk), .reset(rst_n), .enable(enable),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .pixel_byte(pixel_byte), .hsync(hsync), .vsync(vsync),
    .frame_start(frame_start), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Frame-buffer model: one-clock read latency, byte = low address bits.
  always @(posedge clk) begin
    if (rd_en) rd_data <= rd_addr[7:0];
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input exp_t e);
    check("pixel_byte", 32'(pixel_byte), 32'(e.b));
    check("hsync", 32'(hsync), 32'(e.hs));
    check("vsync", 32'(vsync), 32'(e.vs));
    check("frame_start", 32'(frame_start), 32'(e.fs));
  endtask

  task automatic check_idle_outputs();
    check("idle_rd_en", 32'(rd_en), 32'd0);
    check_out(BLANK);
    check("idle_busy", 32'(busy), 32'd0);
  endtask

  // One pixel period: read-issue edge, then the mid-pixel edge.
  task automatic step_pixel();
    exp_t e;
    logic vis;
    @(posedge clk);
    @(negedge clk);
    e = (sb.size() > 0) ? sb.pop_front() : BLANK;
    check_out(e);
    vis = (mx < 4) && (my < 3);
    check("rd_en", 32'(rd_en), 32'(vis));
    if (vis) check("rd_addr", 32'(rd_addr), 32'(my * 4 + mx));
    check("busy", 32'(busy), 32'd1);
    sb.push_back('{b: vis ? 8'(my * 4 + mx) : 8'h00,
                   hs: (mx != 5), vs: (my != 4), fs: (mx == 0) && (my == 0)});
    mx++;
    if (mx == HT) begin
      mx = 0;
      my = (my == VT - 1) ? 0 : my + 1;
    end
    @(posedge clk);
    @(negedge clk);
    check("rd_en_width", 32'(rd_en), 32'd0);
    check("frame_start_width", 32'(frame_start), 32'd0);
  endtask

  initial begin
    exp_t e;
    int   px, py;
    rst_n  = 1'b0;
    enable = 1'b0;
    repeat (3) @(negedge clk);
    check_idle_outputs();
    rst_n = 1'b1;

    // Idle with enable low: nothing moves.
    repeat (20) begin
      @(negedge clk);
      check_idle_outputs();
    end

    // Frame 1: plain scan.
    enable = 1'b1;
    @(posedge clk);
    repeat (HT * VT) step_pixel();

    // Frame 2: drop enable then re-assert while draining; scan must not hiccup.
    for (int k = 0; k < HT * VT; k++) begin
      px = mx;
      py = my;
      step_pixel();
      if (px == 1 && py == 0) enable = 1'b0;
      if (px == 3 && py == 3) enable = 1'b1;
    end

    // Frame 3: drop enable mid-frame; frame completes, flushes, then idles.
    for (int k = 0; k < HT * VT; k++) begin
      px = mx;
      py = my;
      step_pixel();
      if (px == 2 && py == 1) enable = 1'b0;
    end
    @(posedge clk);
    @(negedge clk);
    e = (sb.size() > 0) ? sb.pop_front() : BLANK;
    check_out(e);
    check("flush_rd_en", 32'(rd_en), 32'd0);
    check("flush_busy", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check("flush_busy_mid", 32'(busy), 32'd1);
    @(posedge clk);
    @(negedge clk);
    check_idle_outputs();
    check("idle_rd_addr", 32'(rd_addr), 32'd0);
    repeat (6) begin
      @(negedge clk);
      check_idle_outputs();
    end

    // Fresh scan interrupted by async reset at pixel (3,2).
    enable = 1'b1;
    mx = 0;
    my = 0;
    @(posedge clk);
    while (!(mx == 4 && my == 2)) step_pixel();
    check("pre_reset_pixel", 32'(pixel_byte), 32'd10);
    #2 rst_n = 1'b0;
    #1;
    check_idle_outputs();
    check("reset_rd_addr", 32'(rd_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
    mx = 0;
    my = 0;
    @(posedge clk);
    repeat (16) step_pixel();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
